// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes, fault causes, FSM states.
// Also a helper giving the byte count of a legal access size.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD,
    ILLEGAL
  } lsu_size_e;

  typedef enum logic [1:0] {
    OK,
    MISALIGNED,
    OUT_OF_RANGE,
    ILLEGAL_SIZE
  } lsu_fault_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(lsu_size_e s);
    logic [2:0] n;
    n = 3'd1 << s;
    return n;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response bundle and data-memory port bundle.
// The LSU is the slave of lsu_if and the master of lsu_mem_if.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [TAG_WIDTH-1:0]  resp_tag;
  logic [1:0]            resp_fault;

  modport master (
    output req_valid, req_store, req_size,
    output req_unsigned, req_addr, req_wdata,
    output req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data,
    input  resp_tag, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  req_tag, resp_ready,
    output req_ready, resp_valid, resp_data,
    output resp_tag, resp_fault
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [2:0]            bytes_to_write;
  logic [DATA_WIDTH-1:0] fetched_data;

  modport master (
    output fetch_addr, write_addr,
    output write_data, bytes_to_write,
    input  fetched_data
  );

  modport slave (
    input  fetch_addr, write_addr,
    input  write_data, bytes_to_write,
    output fetched_data
  );
endinterface

// File: rtl/load_store_unit_extend.sv
// Sign/zero extension of a fetched word down to the requested access size.
// Word accesses pass through untouched.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  lsu_size_e             size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] data
);

  logic s8;
  logic s16;

  assign s8  = ~uns & raw[7];
  assign s16 = ~uns & raw[15];

  always_comb begin
    data = raw;
    unique case (1'b1)
      size == BYTE: data = {{(DATA_WIDTH-8){s8}}, raw[7:0]};
      size == HALF: data = {{(DATA_WIDTH-16){s16}}, raw[15:0]};
      default:      data = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between execute and data memory.
// Checks size/alignment/range, drives the memory, returns an extended response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [63:0] MEM_BYTE_SIZE = 64'h1000,
  parameter int          ACCESS_CYCLES = 1,
  parameter int          TAG_WIDTH     = 5
) (
  input logic        clk,
  input logic        rst,
  lsu_if.slave       lsu,
  lsu_mem_if.master  mem
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  lsu_state_e            state;
  lsu_state_e            state_n;
  logic [CW-1:0]         cnt;
  logic                  store_q;
  lsu_size_e             size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  lsu_fault_e            fault_q;

  logic                  accept;
  logic                  last;
  lsu_size_e             in_size;
  logic [2:0]            in_bytes;
  logic [1:0]            in_mask;
  logic [ADDR_WIDTH:0]   end_addr;
  lsu_fault_e            in_fault;
  logic [DATA_WIDTH-1:0] ext;

  assign in_size  = lsu_size_e'(lsu.req_size);
  assign in_bytes = size_bytes(in_size);
  assign in_mask  = in_bytes[1:0] - 2'd1;
  // One bit wider so an access ending exactly at the top cannot wrap.
  assign end_addr = {1'b0, lsu.req_addr}
                  + (ADDR_WIDTH+1)'(in_bytes);

  always_comb begin
    in_fault = OK;
    priority case (1'b1)
      in_size == ILLEGAL:
        in_fault = ILLEGAL_SIZE;
      (lsu.req_addr[1:0] & in_mask) != 2'd0:
        in_fault = MISALIGNED;
      64'(end_addr) > MEM_BYTE_SIZE:
        in_fault = OUT_OF_RANGE;
      default:
        in_fault = OK;
    endcase
  end

  assign last = (cnt == '0);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu.req_valid) begin
          accept  = 1'b1;
          state_n = (in_fault == OK) ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (last) state_n = RESP;
      end
      RESP: begin
        if (lsu.resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      store_q <= 1'b0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      fault_q <= OK;
    end else begin
      state <= state_n;
      if (accept) begin
        store_q <= lsu.req_store;
        size_q  <= in_size;
        uns_q   <= lsu.req_unsigned;
        addr_q  <= lsu.req_addr;
        wdata_q <= lsu.req_wdata;
        tag_q   <= lsu.req_tag;
        fault_q <= in_fault;
        rdata_q <= '0;
        cnt     <= CW'(ACCESS_CYCLES - 1);
      end else if (state == ACCESS) begin
        if (!last) begin
          cnt <= cnt - 1'b1;
        end else begin
          rdata_q <= store_q ? '0 : ext;
        end
      end
    end
  end

  load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ext (
    .raw  (mem.fetched_data),
    .size (size_q),
    .uns  (uns_q),
    .data (ext)
  );

  assign lsu.req_ready  = (state == IDLE);
  assign lsu.resp_valid = (state == RESP);
  assign lsu.resp_data  = rdata_q;
  assign lsu.resp_tag   = tag_q;
  assign lsu.resp_fault = fault_q;

  assign mem.fetch_addr = addr_q;
  assign mem.write_addr = addr_q;
  assign mem.write_data = wdata_q;

  // Gated by rst so a reset landing on the last ACCESS cycle cannot write.
  always_comb begin
    mem.bytes_to_write = 3'd0;
    if (!rst && state == ACCESS && last && store_q)
      mem.bytes_to_write = size_bytes(size_q);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model.
// Runs with a 3-cycle access so multi-cycle latency and stalls are exercised.
module tb_load_store_unit;

  localparam int AC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lsu_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TAG_WIDTH  (5)
  ) lsu ();

  lsu_mem_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) mm ();

  load_store_unit #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .MEM_BYTE_SIZE (64'h1000),
    .ACCESS_CYCLES (AC),
    .TAG_WIDTH     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lsu (lsu),
    .mem (mm)
  );

  logic [7:0]  mem [4096];
  logic        filled = 1'b0;
  int          npulse = 0;
  logic [2:0]  lastb = 3'd0;
  logic [11:0] fa;

  assign fa = mm.fetch_addr[11:0];
  assign mm.fetched_data = {mem[fa+12'd3], mem[fa+12'd2],
                            mem[fa+12'd1], mem[fa]};

  always @(posedge clk) begin
    if (rst && !filled) begin
      for (int i = 0; i < 4096; i++)
        mem[i] <= 8'(i) ^ 8'h5A;
      filled <= 1'b1;
    end else if (mm.bytes_to_write != 3'd0) begin
      for (int i = 0; i < 4; i++)
        if (i < int'(mm.bytes_to_write))
          mem[mm.write_addr[11:0] + 12'(i)] <= mm.write_data[8*i +: 8];
      npulse <= npulse + 1;
      lastb  <= mm.bytes_to_write;
    end
  end

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [31:0] r_data;
  logic [4:0]  r_tag;
  logic [1:0]  r_fault;
  int          r_lat;
  int          r_bad;
  int          p0;

  task automatic txn(input logic st, input logic [1:0] sz,
                     input logic un, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] tg,
                     input int stall);
    @(negedge clk);
    p0 = npulse;
    lsu.req_valid    = 1'b1;
    lsu.req_store    = st;
    lsu.req_size     = sz;
    lsu.req_unsigned = un;
    lsu.req_addr     = a;
    lsu.req_wdata    = wd;
    lsu.req_tag      = tg;
    check("req_ready_idle", 32'(lsu.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    r_lat = 1;
    r_bad = 0;
    while (!lsu.resp_valid && r_lat < 20) begin
      if (lsu.req_ready) r_bad++;
      @(negedge clk);
      r_lat++;
    end
    r_data  = lsu.resp_data;
    r_tag   = lsu.resp_tag;
    r_fault = lsu.resp_fault;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (lsu.req_ready || !lsu.resp_valid
          || lsu.resp_data !== r_data
          || lsu.resp_tag !== r_tag
          || lsu.resp_fault !== r_fault) r_bad++;
    end
    lsu.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lsu.resp_ready = 1'b0;
  endtask

  initial begin
    lsu.req_valid    = 1'b1;
    lsu.req_store    = 1'b1;
    lsu.req_size     = 2'd2;
    lsu.req_unsigned = 1'b0;
    lsu.req_addr     = 32'h80;
    lsu.req_wdata    = 32'h11111111;
    lsu.req_tag      = 5'd9;
    lsu.resp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bytes", 32'(mm.bytes_to_write), 32'd0);
    rst = 1'b0;
    lsu.req_valid = 1'b0;
    #1;
    check("rst_ready", 32'(lsu.req_ready), 32'd1);
    check("rst_valid", 32'(lsu.resp_valid), 32'd0);
    check("rst_data", lsu.resp_data, 32'd0);
    check("rst_tag", 32'(lsu.resp_tag), 32'd0);
    check("rst_fault", 32'(lsu.resp_fault), 32'd0);
    check("rst_faddr", mm.fetch_addr, 32'd0);
    check("rst_waddr", mm.write_addr, 32'd0);
    check("rst_wdata", mm.write_data, 32'd0);
    check("rst_npulse", 32'(npulse), 32'd0);

    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1, 0);
    check("sw_lat", 32'(r_lat), 32'(AC + 1));
    check("sw_pulses", 32'(npulse - p0), 32'd1);
    check("sw_bytes", 32'(lastb), 32'd4);
    check("sw_fault", 32'(r_fault), 32'd0);
    check("sw_data", r_data, 32'd0);
    check("sw_tag", 32'(r_tag), 32'd1);
    check("sw_ready_low", 32'(r_bad), 32'd0);

    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd2, 0);
    check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_fault", 32'(r_fault), 32'd0);
    check("lw_tag", 32'(r_tag), 32'd2);
    check("lw_pulses", 32'(npulse - p0), 32'd0);

    txn(1'b1, 2'd0, 1'b0, 32'h21, 32'hAAAABB80, 5'd3, 0);
    check("sb_bytes", 32'(lastb), 32'd1);
    txn(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 5'd4, 0);
    check("lb_signed", r_data, 32'hFFFFFF80);
    txn(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 5'd5, 0);
    check("lbu", r_data, 32'h00000080);
    txn(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 5'd6, 0);
    check("lb_nb_lo", r_data, 32'h0000007A);
    txn(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 5'd7, 0);
    check("lb_nb_hi", r_data, 32'h00000078);

    txn(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 5'd8, 0);
    check("mis_fault", 32'(r_fault), 32'd1);
    check("mis_lat", 32'(r_lat), 32'd1);
    check("mis_data", r_data, 32'd0);
    txn(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFF, 5'd9, 0);
    check("mis_st_fault", 32'(r_fault), 32'd1);
    check("mis_st_pulse", 32'(npulse - p0), 32'd0);
    txn(1'b0, 2'd3, 1'b0, 32'h1001, 32'h0, 5'd10, 0);
    check("ill_fault", 32'(r_fault), 32'd3);
    check("ill_lat", 32'(r_lat), 32'd1);
    txn(1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 5'd11, 0);
    check("mis_prio", 32'(r_fault), 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 5'd12, 0);
    check("oor_fault", 32'(r_fault), 32'd2);
    txn(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234, 5'd13, 0);
    check("oor_st_fault", 32'(r_fault), 32'd2);
    check("oor_st_pulse", 32'(npulse - p0), 32'd0);
    txn(1'b0, 2'd0, 1'b0, 32'h1000, 32'h0, 5'd14, 0);
    check("oor_byte", 32'(r_fault), 32'd2);
    txn(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 5'd15, 0);
    check("top_word_f", 32'(r_fault), 32'd0);
    check("top_word_d", r_data, 32'hA5A4A7A6);
    txn(1'b0, 2'd1, 1'b0, 32'hFFE, 32'h0, 5'd16, 0);
    check("top_half_s", r_data, 32'hFFFFA5A4);
    txn(1'b0, 2'd1, 1'b1, 32'hFFE, 32'h0, 5'd17, 0);
    check("top_half_u", r_data, 32'h0000A5A4);
    check("top_half_f", 32'(r_fault), 32'd0);

    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd21, 5);
    check("stall_lat", 32'(r_lat), 32'(AC + 1));
    check("stall_data", r_data, 32'hDEADBEEF);
    check("stall_tag", 32'(r_tag), 32'd21);
    check("stall_stable", 32'(r_bad), 32'd0);

    @(negedge clk);
    p0 = npulse;
    lsu.req_valid = 1'b1;
    lsu.req_store = 1'b1;
    lsu.req_size  = 2'd2;
    lsu.req_addr  = 32'h40;
    lsu.req_wdata = 32'h12345678;
    lsu.req_tag   = 5'd30;
    @(posedge clk);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    repeat (AC - 1) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmid_bytes", 32'(mm.bytes_to_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmid_pulses", 32'(npulse - p0), 32'd0);
    check("rmid_ready", 32'(lsu.req_ready), 32'd1);
    check("rmid_valid", 32'(lsu.resp_valid), 32'd0);
    check("rmid_data", lsu.resp_data, 32'd0);
    check("rmid_tag", 32'(lsu.resp_tag), 32'd0);
    check("rmid_fault", 32'(lsu.resp_fault), 32'd0);
    check("rmid_faddr", mm.fetch_addr, 32'd0);
    check("rmid_wdata", mm.write_data, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd31, 0);
    check("rmid_old", r_data, 32'h19181B1A);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
